// File: rtl/offchip_pkg.sv
// Shared types and default parameters for the off-chip byte link arbiter.
// The arbiter holds one byte and offers it to the serializer once buffer room is confirmed.
package offchip_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } link_state_e;

    localparam int unsigned DEF_NREQ      = 4;
    localparam int unsigned DEF_CREDITS   = 8;
    localparam int unsigned DEF_SLOTS_PB  = 2;
    localparam int unsigned DEF_RET_SLOTS = 4;
    localparam int unsigned DEF_CW        = 4;

    localparam int unsigned SRC_W  = 3;
    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches from the slot after the last winner and wraps, returning a one-hot grant and its index.
module rr_pick
    import offchip_pkg::*;
#(
    parameter int unsigned N = DEF_NREQ
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [SRC_W-1:0] idx,
    output logic             any
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    always_comb begin : pick
        int unsigned cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // The last winner is visited last, so it only wins again when it is alone.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last) + k) % N;
            if (!any && req[IW'(cand)]) begin
                any               = 1'b1;
                grant[IW'(cand)]  = 1'b1;
                idx               = SRC_W'(cand);
            end
        end
    end

endmodule

// File: rtl/offchip_link_arbiter.sv
// Round-robin arbiter sharing the off-chip byte link between NREQ sources.
// A byte is accepted only when the serializer is known to have nibble slots free for it.
module offchip_link_arbiter
    import offchip_pkg::*;
#(
    parameter int unsigned NREQ      = DEF_NREQ,
    parameter int unsigned CREDITS   = DEF_CREDITS,
    parameter int unsigned SLOTS_PB  = DEF_SLOTS_PB,
    parameter int unsigned RET_SLOTS = DEF_RET_SLOTS,
    parameter int unsigned CW        = DEF_CW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   link_valid,
    output logic [BYTE_W-1:0]      link_data,
    output logic [SRC_W-1:0]       link_src,
    input  logic                   link_ready,
    input  logic                   credit_ret,
    output logic [CW-1:0]          credits,
    output logic                   err_ovf
);

    localparam int unsigned SW = CW + 1;

    link_state_e       state;
    logic [SRC_W-1:0]  rr_ptr;

    logic [NREQ-1:0]   pick_grant;
    logic [SRC_W-1:0]  pick_idx;
    logic              pick_any;
    logic [BYTE_W-1:0] pick_data;

    logic              slot_free;
    logic              credit_ok;
    logic              capture;

    logic [CW:0]       credit_sum;
    logic              credit_ovf;
    logic [CW-1:0]     credit_next;

    rr_pick #(
        .N(NREQ)
    ) u_pick (
        .req   (req_valid),
        .last  (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin : data_mux
        pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                pick_data = pick_data | req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // The holding register can take a byte when empty or when its byte leaves this cycle.
    assign slot_free = (state == EMPTY) || link_ready;
    assign credit_ok = credits >= CW'(SLOTS_PB);
    assign capture   = !rst && pick_any && credit_ok && slot_free;
    assign req_ready = capture ? pick_grant : '0;

    // Wide enough that a return on a full counter is seen as overflow instead of wrapping.
    assign credit_sum  = SW'(credits)
                       + (credit_ret ? SW'(RET_SLOTS) : SW'(0))
                       - (capture    ? SW'(SLOTS_PB)  : SW'(0));
    assign credit_ovf  = credit_sum > SW'(CREDITS);
    assign credit_next = credit_ovf ? CW'(CREDITS) : credit_sum[CW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            link_valid <= 1'b0;
            link_data  <= '0;
            link_src   <= '0;
            rr_ptr     <= SRC_W'(NREQ - 1);
            credits    <= CW'(CREDITS);
            err_ovf    <= 1'b0;
        end else begin
            credits <= credit_next;
            if (credit_ovf) begin
                err_ovf <= 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (capture) begin
                        state      <= FULL;
                        link_valid <= 1'b1;
                        link_data  <= pick_data;
                        link_src   <= pick_idx;
                        rr_ptr     <= pick_idx;
                    end
                end
                FULL: begin
                    if (capture) begin
                        link_data <= pick_data;
                        link_src  <= pick_idx;
                        rr_ptr    <= pick_idx;
                    end else if (link_ready) begin
                        state      <= EMPTY;
                        link_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    link_valid <= 1'b0;
                end
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

    a_no_grant_without_credit: assert property (@(posedge clk) disable iff (rst)
        (credits < CW'(SLOTS_PB)) |-> (req_ready == '0));

    a_credit_ceiling: assert property (@(posedge clk) disable iff (rst)
        credits <= CW'(CREDITS));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (link_valid && !link_ready) |=> ($stable(link_data) && $stable(link_src)));

endmodule

// File: tb/tb_offchip_link_arbiter.sv
// Self-checking bench for offchip_link_arbiter against a cycle-level behavioural model
// of the round-robin, credit and holding-register rules.
module tb_offchip_link_arbiter;

    localparam int NREQ = 4;
    localparam int CRED = 8;
    localparam int SPB  = 2;
    localparam int RET  = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              link_valid;
    logic [7:0]        link_data;
    logic [2:0]        link_src;
    logic              link_ready;
    logic              credit_ret;
    logic [3:0]        credits;
    logic              err_ovf;

    offchip_link_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .link_valid (link_valid),
        .link_data  (link_data),
        .link_src   (link_src),
        .link_ready (link_ready),
        .credit_ret (credit_ret),
        .credits    (credits),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int         m_credits;
    int         m_last;
    bit         m_full;
    bit         m_err;
    logic [7:0] m_data;
    int         m_src;

    logic [7:0]      pdata [NREQ];
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] obs_ready;
    int              last_win;

    task automatic model_reset();
        m_credits = CRED;
        m_last    = NREQ - 1;
        m_full    = 1'b0;
        m_err     = 1'b0;
        m_data    = 8'h00;
        m_src     = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        link_ready = 1'b0;
        credit_ret = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    // Drives one cycle, samples req_ready before the edge and advances the model.
    task automatic drive_cycle(input logic [NREQ-1:0] v, input bit lr, input bit ret);
        int w;
        int sum;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = pdata[i];
        req_valid  = v;
        link_ready = lr;
        credit_ret = ret;
        #1;
        obs_ready = req_ready;
        w = -1;
        if (v != '0 && m_credits >= SPB && (!m_full || lr)) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (w < 0 && v[c]) w = c;
            end
        end
        exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
        @(posedge clk);
        sum = m_credits + (ret ? RET : 0) - ((w >= 0) ? SPB : 0);
        if (sum > CRED) begin
            sum   = CRED;
            m_err = 1'b1;
        end
        m_credits = sum;
        if (w >= 0) begin
            m_full = 1'b1;
            m_data = pdata[w];
            m_src  = w;
            m_last = w;
            pdata[w] = 8'($urandom);
        end else if (m_full && lr) begin
            m_full = 1'b0;
        end
        last_win = w;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++; if (link_valid !== 1'b0) begin bad++; $display("FAIL reset_link_valid: got %b want 0", link_valid); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        total++; if (credits !== 4'd8) begin bad++; $display("FAIL reset_credits: got %0d want 8", credits); end
        total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL reset_err_ovf: got %b want 0", err_ovf); end
        total++; if (link_src !== 3'd0 || link_data !== 8'h00) begin bad++; $display("FAIL reset_link_regs: got src=%0d data=%h want 0/00", link_src, link_data); end
    endtask

    task automatic test_single();
        apply_reset();
        pdata[2] = 8'hA5;
        drive_cycle(4'b0100, 1'b1, 1'b0);
        total++; if (obs_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", obs_ready); end
        total++; if (link_valid !== 1'b1 || link_data !== 8'hA5 || link_src !== 3'd2) begin bad++; $display("FAIL single_link: got v=%b data=%h src=%0d want 1/A5/2", link_valid, link_data, link_src); end
        total++; if (credits !== 4'd6) begin bad++; $display("FAIL single_credits: got %0d want 6", credits); end
        drive_cycle(4'b0000, 1'b1, 1'b0);
        total++; if (link_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got link_valid=%b want 0", link_valid); end
    endtask

    task automatic test_back_to_back();
        int expect_src;
        apply_reset();
        for (int i = 0; i < NREQ; i++) pdata[i] = 8'($urandom);
        for (int n = 0; n < 12; n++) begin
            drive_cycle(4'b1111, 1'b1, 1'b1);
            expect_src = n % NREQ;
            total++; if (obs_ready !== (NREQ'(1) << expect_src)) begin bad++; $display("FAIL b2b_grant[%0d]: got %b want src %0d", n, obs_ready, expect_src); end
            total++; if (link_valid !== 1'b1 || link_src !== 3'(expect_src) || link_data !== m_data) begin bad++; $display("FAIL b2b_link[%0d]: got v=%b src=%0d data=%h want 1/%0d/%h", n, link_valid, link_src, link_data, expect_src, m_data); end
            total++; if (credits < 4'd6 || credits !== 4'(m_credits)) begin bad++; $display("FAIL b2b_credits[%0d]: got %0d want %0d", n, credits, m_credits); end
        end
    endtask

    task automatic test_credit_exhaust();
        int grants;
        int order [$];
        apply_reset();
        grants = 0;
        for (int n = 0; n < 8; n++) begin
            drive_cycle(4'b1111, 1'b1, 1'b0);
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL exhaust_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
            if (obs_ready != '0) grants++;
        end
        total++; if (grants != 4) begin bad++; $display("FAIL exhaust_count: got %0d want 4", grants); end
        total++; if (credits !== 4'd0) begin bad++; $display("FAIL exhaust_credits: got %0d want 0", credits); end
        grants = 0;
        drive_cycle(4'b1111, 1'b1, 1'b1);
        for (int n = 0; n < 6; n++) begin
            if (n > 0) drive_cycle(4'b1111, 1'b1, 1'b0);
            if (obs_ready != '0) begin
                grants++;
                for (int i = 0; i < NREQ; i++) if (obs_ready[i]) order.push_back(i);
            end
        end
        total++; if (grants != 2) begin bad++; $display("FAIL refill_count: got %0d want 2", grants); end
        total++; if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin bad++; $display("FAIL refill_order: got %p want '{0,1}", order); end
    endtask

    task automatic test_stall();
        logic [7:0] held;
        apply_reset();
        for (int i = 0; i < NREQ; i++) pdata[i] = 8'($urandom);
        drive_cycle(4'b1111, 1'b1, 1'b0);
        held = link_data;
        for (int n = 0; n < 5; n++) begin
            drive_cycle(4'b1111, 1'b0, 1'b0);
            total++; if (obs_ready !== '0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", n, obs_ready); end
            total++; if (link_valid !== 1'b1 || link_data !== held || link_src !== 3'd0 || credits !== 4'd6) begin bad++; $display("FAIL stall_hold[%0d]: got v=%b data=%h src=%0d cr=%0d want 1/%h/0/6", n, link_valid, link_data, link_src, credits, held); end
        end
        drive_cycle(4'b1111, 1'b1, 1'b0);
        total++; if (obs_ready !== 4'b0010 || link_src !== 3'd1) begin bad++; $display("FAIL stall_release: got ready=%b src=%0d want 0010/1", obs_ready, link_src); end
    endtask

    task automatic test_overflow();
        apply_reset();
        drive_cycle(4'b0000, 1'b0, 1'b1);
        total++; if (credits !== 4'd8 || err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got cr=%0d err=%b want 8/1", credits, err_ovf); end
        for (int n = 0; n < 3; n++) drive_cycle(4'b0000, 1'b0, 1'b0);
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", err_ovf); end
        apply_reset();
        drive_cycle(4'b0001, 1'b1, 1'b0);
        drive_cycle(4'b0010, 1'b1, 1'b1);
        total++; if (obs_ready !== 4'b0010 || credits !== 4'd8 || err_ovf !== 1'b0) begin bad++; $display("FAIL ret_with_capture: got ready=%b cr=%0d err=%b want 0010/8/0", obs_ready, credits, err_ovf); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive_cycle(4'b1111, 1'b0, 1'b0);
        drive_cycle(4'b1111, 1'b0, 1'b1);
        total++; if (err_ovf !== 1'b1 || link_valid !== 1'b1) begin bad++; $display("FAIL mid_setup: got err=%b v=%b want 1/1", err_ovf, link_valid); end
        apply_reset();
        total++; if (link_valid !== 1'b0 || credits !== 4'd8 || err_ovf !== 1'b0) begin bad++; $display("FAIL mid_reset: got v=%b cr=%0d err=%b want 0/8/0", link_valid, credits, err_ovf); end
        drive_cycle(4'b1111, 1'b1, 1'b0);
        total++; if (obs_ready !== 4'b0001 || link_src !== 3'd0) begin bad++; $display("FAIL mid_first_grant: got ready=%b src=%0d want 0001/0", obs_ready, link_src); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pend;
        bit lr;
        bit ret;
        apply_reset();
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 8'($urandom);
                end
            end
            lr  = ($urandom_range(0, 3) != 0);
            ret = ($urandom_range(0, 4) == 0);
            drive_cycle(pend, lr, ret);
            if (last_win >= 0) pend[last_win] = 1'b0;
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
            total++; if (link_valid !== m_full || credits !== 4'(m_credits) || err_ovf !== m_err) begin bad++; $display("FAIL rand_state[%0d]: got v=%b cr=%0d err=%b want %b/%0d/%b", n, link_valid, credits, err_ovf, m_full, m_credits, m_err); end
            if (m_full) begin
                total++; if (link_data !== m_data || link_src !== 3'(m_src)) begin bad++; $display("FAIL rand_link[%0d]: got data=%h src=%0d want %h/%0d", n, link_data, link_src, m_data, m_src); end
            end
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        link_ready = 1'b0;
        credit_ret = 1'b0;
        last_win   = -1;
        for (int i = 0; i < NREQ; i++) pdata[i] = 8'h00;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_exhaust();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
